// File: rtl/bus_pkg.sv
// Shared address map and read-source select for the CPU byte-bus responder.
package bus_pkg;

    localparam logic [1:0]  IO_SEL    = 2'b11;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_CLK  = 18'h30004;

    typedef enum logic {
        SEL_RAM,
        SEL_IO
    } sel_e;

    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; push and pop may coincide at any fill level.
module byte_fifo #(
    parameter int LOG = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [7:0]   din,
    input  logic         pop,
    output logic [7:0]   dout,
    output logic         full,
    output logic         empty,
    output logic [LOG:0] count
);

    localparam int DEPTH = 1 << LOG;
    localparam logic [LOG:0] PTR_ONE = (LOG + 1)'(1);

    logic [7:0]   mem [DEPTH];
    logic [LOG:0] wr_ptr;
    logic [LOG:0] rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[LOG] != rd_ptr[LOG]) && (wr_ptr[LOG-1:0] == rd_ptr[LOG-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[LOG-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[LOG-1:0]] <= din;
    end

endmodule

// File: rtl/cpu_bus_responder.sv
// Slave end of the CPU byte bus: RAM/IO decode, UART FIFOs, cycle counter, stop flag.
// RESP_UART_RX_EN builds the RX FIFO behind the 0x30000 read port.
module cpu_bus_responder
    import bus_pkg::*;
#(
    parameter int RAM_AW  = 17,
    parameter int TXQ_LOG = 3,
    parameter int RXQ_LOG = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic [31:0]       bus_a,
    input  logic [7:0]        bus_wdata,
    input  logic              bus_wr,
    output logic [7:0]        bus_rdata,
    output logic              io_buffer_full,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              prog_done
);

    localparam logic [TXQ_LOG:0] TX_NEAR_FULL = (TXQ_LOG + 1)'((1 << TXQ_LOG) - 1);

    logic [17:0]      addr;
    logic             io;
    logic             rd_acc;
    logic             wr_acc;
    logic             uart_hit;
    logic             clk_hit;
    logic             clk_exact;
    logic [7:0]       io_rd_val;
    logic [7:0]       rx_rd_val;
    sel_e             sel_q;
    logic [7:0]       io_rdata_q;
    logic             rd_live_q;
    logic [31:0]      cycle_cnt;
    logic [31:0]      cnt_snap;
    logic             tx_push;
    logic [7:0]       tx_din;
    logic             tx_full;
    logic             tx_empty;
    logic [TXQ_LOG:0] tx_count;

    assign addr      = bus_a[17:0];
    assign io        = (addr[17:16] == IO_SEL);
    assign rd_acc    = rdy_in & ~bus_wr;
    assign wr_acc    = rdy_in & bus_wr;
    assign uart_hit  = (addr == ADDR_UART);
    assign clk_exact = (addr == ADDR_CLK);
    assign clk_hit   = (addr[17:2] == ADDR_CLK[17:2]);

    assign ram_a     = bus_a[RAM_AW-1:0];
    assign ram_we    = wr_acc & ~io;
    assign ram_wdata = bus_wdata;

    // The stop write pushes a NUL marker, bypassing the zero filter on UART writes.
    assign tx_push = wr_acc & io & ((uart_hit & (bus_wdata != 8'h00)) | clk_exact);
    assign tx_din  = clk_exact ? 8'h00 : bus_wdata;

    byte_fifo #(.LOG(TXQ_LOG)) u_tx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (tx_push),
        .din   (tx_din),
        .pop   (tx_valid & tx_ready),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    assign tx_valid       = ~tx_empty;
    assign io_buffer_full = tx_full | (tx_count >= TX_NEAR_FULL);

`ifdef RESP_UART_RX_EN
    logic [7:0]       rx_dout;
    logic             rx_full;
    logic             rx_empty;
    logic [RXQ_LOG:0] rx_count;

    byte_fifo #(.LOG(RXQ_LOG)) u_rx_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .push  (rx_valid),
        .din   (rx_data),
        .pop   (rd_acc & io & uart_hit),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign rx_rd_val = rx_empty ? 8'h00 : rx_dout;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus_a[31:18], rx_full, rx_count};
`else
    assign rx_rd_val = 8'h00;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus_a[31:18], rx_data, rx_valid};
`endif

    // Byte 0 comes from the live counter at the moment it is snapshotted.
    always_comb begin
        io_rd_val = 8'h00;
        if (uart_hit) begin
            io_rd_val = rx_rd_val;
        end else if (clk_hit) begin
            io_rd_val = clk_exact ? cycle_cnt[7:0] : word_byte(cnt_snap, addr[1:0]);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            sel_q      <= SEL_RAM;
            io_rdata_q <= 8'h00;
            rd_live_q  <= 1'b0;
        end else if (rd_acc) begin
            sel_q      <= io ? SEL_IO : SEL_RAM;
            io_rdata_q <= io ? io_rd_val : 8'h00;
            rd_live_q  <= 1'b1;
        end
    end

    // Until the first read after reset there is no RAM data worth forwarding.
    assign bus_rdata = !rd_live_q        ? 8'h00 :
                       (sel_q == SEL_IO) ? io_rdata_q : ram_rdata;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            cycle_cnt <= 32'h0;
            cnt_snap  <= 32'h0;
            prog_done <= 1'b0;
        end else begin
            if (!prog_done)               cycle_cnt <= cycle_cnt + 32'h1;
            if (rd_acc & io & clk_exact)  cnt_snap  <= cycle_cnt;
            if (wr_acc & io & clk_exact)  prog_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder with a queue-based reference model.
// Build with RESP_UART_RX_EN defined to exercise the RX read path.
module tb_cpu_bus_responder;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] bus_a = 32'h0;
    logic [7:0]  bus_wdata = 8'h00;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        prog_done;

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    cpu_bus_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .bus_a          (bus_a),
        .bus_wdata      (bus_wdata),
        .bus_wr         (bus_wr),
        .bus_rdata      (bus_rdata),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .prog_done      (prog_done)
    );

    // Synchronous-read RAM behind the responder.
    logic [7:0] ram_mem [0:(1<<17)-1];
    initial for (int i = 0; i < (1 << 17); i++) ram_mem[i] = 8'h00;
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_wdata;
        ram_rdata <= ram_mem[ram_a];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: byte map for RAM, queues for the FIFOs, plain integers for the counter.
    logic [7:0]  model_mem [int];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [7:0]  tx_log [$];
    logic [31:0] m_cnt = 0;
    logic [31:0] m_snap = 0;
    logic        m_done = 0;
    logic [7:0]  m_rdata = 0;
    int          rd_mode = 0;
    bit          model_live = 0;

    always @(posedge clk_in) begin : model_proc
        logic [17:0] a;
        logic        io_acc;
        logic        was_done;
        logic [7:0]  v;
        model_live = 1;
        if (!rst_in) begin
            txq.delete();
            rxq.delete();
            m_cnt   = 0;
            m_snap  = 0;
            m_done  = 0;
            rd_mode = 0;
        end else begin
            a        = bus_a[17:0];
            io_acc   = (a[17:16] == 2'b11);
            was_done = m_done;
            v        = 8'h00;
            if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
            if (rdy_in && !bus_wr) begin
                if (!io_acc) begin
                    v = model_mem.exists(int'(a[16:0])) ? model_mem[int'(a[16:0])] : 8'h00;
                end else if (a == 18'h30000) begin
`ifdef RESP_UART_RX_EN
                    if (rxq.size() > 0) v = rxq.pop_front();
`endif
                end else if (a == 18'h30004) begin
                    m_snap = m_cnt;
                    v = m_cnt[7:0];
                end else if (a >= 18'h30005 && a <= 18'h30007) begin
                    v = m_snap[8*a[1:0] +: 8];
                end
                rd_mode = 1;
                m_rdata = v;
            end
`ifdef RESP_UART_RX_EN
            if (rx_valid && rxq.size() < 8) rxq.push_back(rx_data);
`endif
            if (rdy_in && bus_wr) begin
                if (!io_acc) begin
                    model_mem[int'(a[16:0])] = bus_wdata;
                end else if (a == 18'h30000) begin
                    if (bus_wdata != 8'h00 && txq.size() < 8) txq.push_back(bus_wdata);
                end else if (a == 18'h30004) begin
                    if (txq.size() < 8) txq.push_back(8'h00);
                    m_done = 1;
                end
                if (rd_mode == 1) rd_mode = 2;
            end
            if (!was_done) m_cnt = m_cnt + 1;
        end
    end

    // Compare process: every falling edge, against the model.
    always @(negedge clk_in) begin
        if (model_live) begin
            if (rd_mode == 0)      checkOutput("rdata_idle", bus_rdata, 8'h00);
            else if (rd_mode == 1) checkOutput("rdata", bus_rdata, m_rdata);
            checkOutput("tx_valid", tx_valid, txq.size() > 0);
            if (txq.size() > 0) checkOutput("tx_data", tx_data, txq[0]);
            checkOutput("io_buffer_full", io_buffer_full, txq.size() >= 7);
            checkOutput("prog_done", prog_done, m_done);
            checkOutput("ram_we", ram_we, rst_in && rdy_in && bus_wr && (bus_a[17:16] != 2'b11));
            if (ram_we) begin
                checkOutput("ram_a", ram_a, bus_a[16:0]);
                checkOutput("ram_wdata", ram_wdata, bus_wdata);
            end
            if (rst_in && tx_valid && tx_ready) tx_log.push_back(tx_data);
        end
    end

    task automatic applyStimulus(input logic rdy, input logic [31:0] a, input logic [7:0] d, input logic wr);
        rdy_in = rdy;
        bus_a = a;
        bus_wdata = d;
        bus_wr = wr;
        @(posedge clk_in);
        #1;
        rdy_in = 1'b0;
        bus_wr = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) applyStimulus(1'b0, bus_a, 8'h00, 1'b0);
    endtask

    task automatic read_byte(input logic [31:0] a, output logic [7:0] d);
        applyStimulus(1'b1, a, 8'h00, 1'b0);
        d = bus_rdata;
    endtask

    task automatic read_word(input logic [31:0] base, output logic [31:0] w);
        logic [7:0] b;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            read_byte(base + 32'(k), b);
            w[8*k +: 8] = b;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0]  d;
        logic [7:0]  held;
        logic [31:0] w1, w2, w3, w4;
        bit          drained;

        idle_cycles(3);
        checkOutput("reset_rdata", bus_rdata, 8'h00);
        checkOutput("reset_tx_valid", tx_valid, 1'b0);
        checkOutput("reset_full", io_buffer_full, 1'b0);
        checkOutput("reset_prog_done", prog_done, 1'b0);
        rst_in = 1'b1;

        // RAM write then read, data one cycle after the read address.
        applyStimulus(1'b1, 32'h0000_0100, 8'hA5, 1'b1);
        applyStimulus(1'b1, 32'h0001_FFFF, 8'h3C, 1'b1);
        read_byte(32'h0000_0100, d);
        checkOutput("t1_ram_a5", d, 8'hA5);
        read_byte(32'h0001_FFFF, d);
        checkOutput("t1_ram_3c", d, 8'h3C);

        // UART writes with the zero filter.
        tx_ready = 1'b1;
        tx_log.delete();
        applyStimulus(1'b1, 32'h0003_0000, 8'h48, 1'b1);
        applyStimulus(1'b1, 32'h0003_0000, 8'h00, 1'b1);
        applyStimulus(1'b1, 32'hABC3_0000, 8'h69, 1'b1);
        idle_cycles(3);
        checkOutput("t2_log_len", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            checkOutput("t2_log_H", tx_log[0], 8'h48);
            checkOutput("t2_log_i", tx_log[1], 8'h69);
        end
        checkOutput("t2_prog_done", prog_done, 1'b0);

        // Fill TX with the UART stalled.
        tx_ready = 1'b0;
        tx_log.delete();
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(1'b1, 32'h0003_0000, 8'(i), 1'b1);
            if (i == 6) checkOutput("t3_not_full_6", io_buffer_full, 1'b0);
            if (i == 7) checkOutput("t3_full_7", io_buffer_full, 1'b1);
        end
        tx_ready = 1'b1;
        drained = 0;
        for (int c = 0; c < 20 && !drained; c++) begin
            idle_cycles(1);
            if (!tx_valid) drained = 1;
        end
        checkOutput("t3_drain_done", drained, 1'b1);
        for (int i = 0; i < 8; i++)
            checkOutput("t3_drain_order", (i < tx_log.size()) ? 32'(tx_log[i]) : 32'hFFFF_FFFF, 32'(i + 1));
        checkOutput("t3_drain_len", tx_log.size(), 8);

        // Coherent counter word, then stop.
        read_word(32'h0003_0004, w1);
        checkOutput("t4_word_vs_model", w1, m_snap);
        read_word(32'h0003_0004, w2);
        checkOutput("t4_delta", w2 - w1, 32'd4);
        tx_log.delete();
        applyStimulus(1'b1, 32'h0003_0004, 8'h77, 1'b1);
        read_word(32'h0003_0004, w3);
        checkOutput("t4_frozen_value", w3, w2 + 32'd5);
        idle_cycles(5);
        read_word(32'h0003_0004, w4);
        checkOutput("t4_frozen_hold", w4, w3);
        checkOutput("t4_prog_done", prog_done, 1'b1);
        checkOutput("t4_tx_len", tx_log.size(), 1);
        if (tx_log.size() == 1) checkOutput("t4_tx_zero", tx_log[0], 8'h00);

        // RX FIFO path.
        rx_data = 8'h31;
        rx_valid = 1'b1;
        idle_cycles(1);
        rx_data = 8'h32;
        idle_cycles(1);
        rx_valid = 1'b0;
`ifdef RESP_UART_RX_EN
        read_byte(32'h0003_0000, d); checkOutput("t5_rx0", d, 8'h31);
        read_byte(32'h0003_0000, d); checkOutput("t5_rx1", d, 8'h32);
        read_byte(32'h0003_0000, d); checkOutput("t5_rx2", d, 8'h00);
`else
        read_byte(32'h0003_0000, d); checkOutput("t5_rx0", d, 8'h00);
        read_byte(32'h0003_0000, d); checkOutput("t5_rx1", d, 8'h00);
        read_byte(32'h0003_0000, d); checkOutput("t5_rx2", d, 8'h00);
`endif

        // Stalled bus: writes must not land, read data must hold.
        read_byte(32'h0003_0005, held);
        checkOutput("t6_snap_byte1", held, w4[15:8]);
        rdy_in = 1'b0;
        bus_a = 32'h0000_0100;
        bus_wdata = 8'h5A;
        bus_wr = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        checkOutput("t6_rdata_held", bus_rdata, held);
        bus_a = 32'h0003_0000;
        @(posedge clk_in);
        #1;
        bus_wr = 1'b0;
        checkOutput("t6_no_tx", tx_valid, 1'b0);
        read_byte(32'h0000_0100, d);
        checkOutput("t6_ram_kept", d, 8'hA5);

        // Reset in the middle of a TX backlog.
        tx_ready = 1'b0;
        applyStimulus(1'b1, 32'h0003_0000, 8'h41, 1'b1);
        applyStimulus(1'b1, 32'h0003_0000, 8'h42, 1'b1);
        checkOutput("t6_tx_pending", tx_valid, 1'b1);
        rst_in = 1'b0;
        idle_cycles(1);
        checkOutput("t6_reset_tx_valid", tx_valid, 1'b0);
        checkOutput("t6_reset_prog_done", prog_done, 1'b0);
        checkOutput("t6_reset_rdata", bus_rdata, 8'h00);
        rst_in = 1'b1;
        read_word(32'h0003_0004, w1);
        checkOutput("t6_cnt_restart", w1, 32'd0);
        read_word(32'h0003_0004, w2);
        checkOutput("t6_cnt_after4", w2, 32'd4);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
